// File: rtl/bullet_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bullet_ctrl
// Purpose  : Bullet pool controller. Handles fire allocation and per-frame
//            motion, and selects the sprite origin per scan pixel.
//            Optional fire cooldown is enabled by defining BULLET_COOLDOWN_EN.
// Revision : 1.0
// ============================================================================
module bullet_ctrl #(
  parameter int NUM_BULLETS = 4,
  parameter int SPEED       = 4,
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int COOLDOWN    = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_tick_i,
  input  logic                   fire_req_i,
  input  logic [1:0]             fire_dir_i,
  input  logic [10:0]            fire_x_i,
  input  logic [10:0]            fire_y_i,
  output logic                   fire_ack_o,
  input  logic [NUM_BULLETS-1:0] kill_i,
  input  logic [10:0]            x_i,
  input  logic [10:0]            y_i,
  output logic [10:0]            x0_o,
  output logic [10:0]            y0_o,
  output logic [NUM_BULLETS-1:0] active_o
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  localparam int          c_IW    = (NUM_BULLETS > 1) ? $clog2(NUM_BULLETS) : 1;
  localparam logic [11:0] c_SPEED = 12'(SPEED);
  localparam logic [11:0] c_XLIM  = 12'(H_MAX - 8);
  localparam logic [11:0] c_YLIM  = 12'(V_MAX - 8);
  localparam logic [10:0] c_NONE  = 11'h7FF;

  logic [NUM_BULLETS-1:0] act_q, act_d;
  logic [10:0]            bx_q  [NUM_BULLETS];
  logic [10:0]            bx_d  [NUM_BULLETS];
  logic [10:0]            by_q  [NUM_BULLETS];
  logic [10:0]            by_d  [NUM_BULLETS];
  dir_e                   dir_q [NUM_BULLETS];
  dir_e                   dir_d [NUM_BULLETS];

  logic            alloc_ok;
  logic [c_IW-1:0] alloc_idx;
  logic            fire_go;
  logic            cool_ok;
  logic            hit;

`ifdef BULLET_COOLDOWN_EN
  localparam int c_CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  logic [c_CW-1:0] cool_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cool_q <= '0;
    end else if (fire_go) begin
      cool_q <= c_CW'(COOLDOWN);
    end else if (frame_tick_i && (cool_q != '0)) begin
      cool_q <= cool_q - c_CW'(1);
    end
  end

  assign cool_ok = (cool_q == '0);
`else
  assign cool_ok = 1'b1;
`endif

  // Allocation looks only at slot state from the start of the cycle, so a
  // slot being killed this cycle is still busy.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      if (!act_q[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = c_IW'(i);
      end
    end
    fire_go = fire_req_i && alloc_ok && cool_ok && !reset_i;
  end

  always_comb begin
    act_d = act_q;
    bx_d  = bx_q;
    by_d  = by_q;
    dir_d = dir_q;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (act_q[i] && frame_tick_i) begin
        case (dir_q[i])
          DIR_UP:
            if ({1'b0, by_q[i]} < c_SPEED) act_d[i] = 1'b0;
            else                           by_d[i] = by_q[i] - c_SPEED[10:0];
          DIR_DOWN:
            if (({1'b0, by_q[i]} + c_SPEED) > c_YLIM) act_d[i] = 1'b0;
            else                                      by_d[i] = by_q[i] + c_SPEED[10:0];
          DIR_LEFT:
            if ({1'b0, bx_q[i]} < c_SPEED) act_d[i] = 1'b0;
            else                           bx_d[i] = bx_q[i] - c_SPEED[10:0];
          default:
            if (({1'b0, bx_q[i]} + c_SPEED) > c_XLIM) act_d[i] = 1'b0;
            else                                      bx_d[i] = bx_q[i] + c_SPEED[10:0];
        endcase
      end
      if (kill_i[i]) begin
        act_d[i] = 1'b0;
      end
      if (fire_go && (alloc_idx == c_IW'(i))) begin
        act_d[i] = 1'b1;
        bx_d[i]  = fire_x_i;
        by_d[i]  = fire_y_i;
        dir_d[i] = dir_e'(fire_dir_i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      act_q <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        bx_q[i]  <= '0;
        by_q[i]  <= '0;
        dir_q[i] <= DIR_UP;
      end
    end else begin
      act_q <= act_d;
      bx_q  <= bx_d;
      by_q  <= by_d;
      dir_q <= dir_d;
    end
  end

  // Lowest-index covering slot owns the sprite source for this pixel.
  always_comb begin
    hit  = 1'b0;
    x0_o = c_NONE;
    y0_o = c_NONE;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!hit && act_q[i] &&
          (x_i >= bx_q[i]) && ((x_i - bx_q[i]) < 11'd8) &&
          (y_i >= by_q[i]) && ((y_i - by_q[i]) < 11'd8)) begin
        hit  = 1'b1;
        x0_o = bx_q[i];
        y0_o = by_q[i];
      end
    end
  end

  assign fire_ack_o = fire_go;
  assign active_o   = act_q;

endmodule
`default_nettype wire
